// File: rtl/rtc_disp_pkg.sv
// Shared constants, BCD field masks and FSM encoding for the RTC display scheduler.
package rtc_disp_pkg;
    localparam int N_FIELDS = 8;
    localparam int N_SLOTS  = 2 * N_FIELDS;

    localparam logic [2:0] F_SEC   = 3'd0;
    localparam logic [2:0] F_MIN   = 3'd1;
    localparam logic [2:0] F_HOUR  = 3'd2;
    localparam logic [2:0] F_DATE  = 3'd3;
    localparam logic [2:0] F_MONTH = 3'd4;
    localparam logic [2:0] F_YEAR  = 3'd5;
    localparam logic [2:0] F_DOW   = 3'd6;
    localparam logic [2:0] F_WEEK  = 3'd7;

    localparam logic [6:0] ASCII_ZERO  = 7'h30;
    localparam logic [6:0] ASCII_QMARK = 7'h3F;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_GAP, S_PEND, S_COMMIT
    } state_t;

    // Mask applied to the high nibble; strips RTC control bits (CH, 12/24, century).
    function automatic logic [3:0] tens_mask(input logic [2:0] f);
        case (f)
            F_SEC, F_MIN:   return 4'h7;
            F_HOUR, F_DATE: return 4'h3;
            F_MONTH:        return 4'h1;
            F_DOW:          return 4'h0;
            default:        return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] units_mask(input logic [2:0] f);
        return (f == F_DOW) ? 4'h7 : 4'hF;
    endfunction
endpackage

// File: rtl/rtc_display_scheduler_if.sv
// RTC register-read handshake between the scheduler and the RTC bus master.
interface rtc_display_scheduler_if;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic       rd_ack;
    logic [7:0] rd_data;

    modport master (output rd_req, rd_addr, input rd_ack, rd_data);
    modport slave  (input rd_req, rd_addr, output rd_ack, rd_data);
endinterface

// File: rtl/bcd_nibble_to_ascii.sv
// One BCD digit to its ASCII code; anything above 9 shows as '?'.
module bcd_nibble_to_ascii
    import rtc_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] ascii
);
    assign ascii = (nib <= 4'd9) ? ASCII_ZERO + {3'b000, nib} : ASCII_QMARK;
endmodule

// File: rtl/rtc_display_scheduler.sv
// Reads the eight RTC time/date registers into a shadow bank of ASCII codes and
// commits them to the display registers only during vertical blanking.
module rtc_display_scheduler
    import rtc_disp_pkg::*;
#(
    parameter logic [7:0] ADDR_BASE   = 8'h21,
    parameter int         TIMEOUT_CYC = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_tick,
    input  logic                        vblank,
    rtc_display_scheduler_if.master     bus,
    output logic [7*N_SLOTS-1:0]        char_out,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);
    localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

    state_t               state;
    logic [2:0]           idx;
    logic [7:0]           timer;
    logic                 rd_req_q;
    logic [7:0]           rd_addr_q;
    logic [7*N_SLOTS-1:0] shadow;
    logic [6:0]           tens_ascii, units_ascii;

    assign bus.rd_req  = rd_req_q;
    assign bus.rd_addr = rd_addr_q;

    bcd_nibble_to_ascii u_tens  (.nib(bus.rd_data[7:4] & tens_mask(idx)),  .ascii(tens_ascii));
    bcd_nibble_to_ascii u_units (.nib(bus.rd_data[3:0] & units_mask(idx)), .ascii(units_ascii));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= 3'd0;
            timer     <= 8'd0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= ADDR_BASE;
            shadow    <= {N_SLOTS{ASCII_ZERO}};
            char_out  <= {N_SLOTS{ASCII_ZERO}};
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start_tick) begin
                    idx   <= 3'd0;
                    err   <= 1'b0;
                    busy  <= 1'b1;
                    state <= S_REQ;
                end
                S_REQ: begin
                    rd_req_q  <= 1'b1;
                    rd_addr_q <= ADDR_BASE + {5'd0, idx};
                    timer     <= 8'd0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.rd_ack) begin
                        // slot 2k holds units (low bits), slot 2k+1 holds tens
                        shadow[int'(idx)*14 +: 14] <= {tens_ascii, units_ascii};
                        rd_req_q <= 1'b0;
                        state    <= S_GAP;
                    end else if (timer + 8'd1 == TMO) begin
                        rd_req_q <= 1'b0;
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                S_GAP: begin
                    if (idx == 3'd7) begin
                        state <= S_PEND;
                    end else begin
                        idx   <= idx + 3'd1;
                        state <= S_REQ;
                    end
                end
                // Commit is taken on an edge where vblank is sampled high, so the
                // display registers never move outside blanking.
                S_PEND: if (vblank) begin
                    char_out <= shadow;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_COMMIT;
                end
                S_COMMIT: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule
